// File: rtl/thermo_share_gen.sv
// thermo_share_gen: splits four raw thermostat bits into two Boolean shares
// each and hands them, with four fresh gadget randomness bits, to a masked
// consumer over a valid/ready handshake. Randomness comes from a 32-bit Galois
// LFSR that advances 8 steps every cycle, so back-to-back bundles never reuse
// mask bits.
// Optional feature: define THERM_RESEED_EN to add the seed_valid/seed reseed
// port pair; the default build seeds the LFSR only from SEED.
module thermo_share_gen #(
    parameter logic [31:0] SEED       = 32'hACE1_2468, // must be nonzero
    parameter int unsigned WARMUP_CYC = 4              // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        too_cold,
    input  logic        too_hot,
    input  logic        mode,
    input  logic        fan_on,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        too_cold0,
    output logic        too_cold1,
    output logic        too_hot0,
    output logic        too_hot1,
    output logic        mode0,
    output logic        mode1,
    output logic        fan_on0,
    output logic        fan_on1,
    output logic        r0,
    output logic        r1,
    output logic        r2,
    output logic        r3
`ifdef THERM_RESEED_EN
    ,
    input  logic        seed_valid,
    input  logic [31:0] seed
`endif
);

    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [3:0]  WARM_LAST = 4'(WARMUP_CYC - 1);

    typedef enum logic [1:0] {WARMUP, EMPTY, FULL} state_t;

    // Registered output bundle; field order matches the port list.
    typedef struct packed {
        logic too_cold0, too_cold1;
        logic too_hot0,  too_hot1;
        logic mode0,     mode1;
        logic fan_on0,   fan_on1;
        logic r0, r1, r2, r3;
    } bundle_t;

    // Eight unrolled right-shift Galois steps per clock.
    function automatic logic [31:0] lfsr_step8(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'h0);
        end
        return v;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] lfsr_q, lfsr_d;
    bundle_t     bundle_q, bundle_d;
    logic        accept;
    logic        reseed;
    logic [31:0] reseed_val;
    logic [7:0]  m;

`ifdef THERM_RESEED_EN
    assign reseed     = seed_valid;
    assign reseed_val = (seed == 32'h0) ? SEED : seed;
`else
    assign reseed     = 1'b0;
    assign reseed_val = SEED;
`endif

    assign m      = lfsr_q[7:0];
    assign accept = in_valid & in_ready;

    // State, warm-up counter, LFSR and output bundle registers.
    always_ff @(posedge clk) begin
        // NOTE: every register here, including the bundle, is reset so no stale shares leak out after reset.
        if (!rst_n) begin
            state_q  <= WARMUP;
            cnt_q    <= 4'd0;
            lfsr_q   <= SEED;
            bundle_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            bundle_q <= bundle_d;
        end
    end

    // Next-state logic: warm-up countdown, then the one-deep EMPTY/FULL buffer.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WARMUP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WARM_LAST) state_d = EMPTY;
            end
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !in_valid) state_d = EMPTY;
            default: state_d = WARMUP;
        endcase
        if (reseed) begin
            state_d = WARMUP;
            cnt_d   = 4'd0;
        end
    end

    // Handshake outputs; in_ready is forced low during reset and reseed.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            EMPTY: in_ready = 1'b1;
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        if (!rst_n || reseed) in_ready = 1'b0;
        if (!rst_n) out_valid = 1'b0;
    end

    // Datapath: LFSR advance/reseed and share masking on acceptance.
    always_comb begin
        lfsr_d   = reseed ? reseed_val : lfsr_step8(lfsr_q);
        bundle_d = bundle_q;
        if (reseed) begin
            bundle_d = '0;
        end else if (accept) begin
            bundle_d.too_cold0 = too_cold ^ m[0];
            bundle_d.too_cold1 = m[0];
            bundle_d.too_hot0  = too_hot ^ m[1];
            bundle_d.too_hot1  = m[1];
            bundle_d.mode0     = mode ^ m[2];
            bundle_d.mode1     = m[2];
            bundle_d.fan_on0   = fan_on ^ m[3];
            bundle_d.fan_on1   = m[3];
            bundle_d.r0        = m[4];
            bundle_d.r1        = m[5];
            bundle_d.r2        = m[6];
            bundle_d.r3        = m[7];
        end
    end

    assign too_cold0 = bundle_q.too_cold0;
    assign too_cold1 = bundle_q.too_cold1;
    assign too_hot0  = bundle_q.too_hot0;
    assign too_hot1  = bundle_q.too_hot1;
    assign mode0     = bundle_q.mode0;
    assign mode1     = bundle_q.mode1;
    assign fan_on0   = bundle_q.fan_on0;
    assign fan_on1   = bundle_q.fan_on1;
    assign r0        = bundle_q.r0;
    assign r1        = bundle_q.r1;
    assign r2        = bundle_q.r2;
    assign r3        = bundle_q.r3;

endmodule

// File: tb/tb_thermo_share_gen.sv
// Testbench for thermo_share_gen (default build, reseed feature disabled).
// A reference LFSR model tracks the DUT; every accepted raw sample pushes its
// expected bundle to a scoreboard queue that is compared whenever out_valid=1.
module tb_thermo_share_gen;

    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready;
    logic too_cold, too_hot, mode, fan_on;
    logic too_cold0, too_cold1, too_hot0, too_hot1;
    logic mode0, mode1, fan_on0, fan_on1;
    logic r0, r1, r2, r3;
    logic [11:0] dut_vec;

    int tests_run = 0;
    int failed    = 0;
    int pushed    = 0;
    int popped    = 0;
    logic [31:0] mdl_lfsr;
    logic [11:0] sb_q[$];
    bit last_in_ready, last_out_valid, last_accept;

    always #5 clk = ~clk;

    thermo_share_gen dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .too_cold(too_cold), .too_hot(too_hot), .mode(mode), .fan_on(fan_on),
        .out_valid(out_valid), .out_ready(out_ready),
        .too_cold0(too_cold0), .too_cold1(too_cold1),
        .too_hot0(too_hot0), .too_hot1(too_hot1),
        .mode0(mode0), .mode1(mode1),
        .fan_on0(fan_on0), .fan_on1(fan_on1),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3)
    );

    assign dut_vec = {too_cold0, too_cold1, too_hot0, too_hot1,
                      mode0, mode1, fan_on0, fan_on1, r0, r1, r2, r3};

    function automatic logic [31:0] step8(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) v = (v >> 1) ^ (v[0] ? POLY : 32'h0);
        return v;
    endfunction

    // raw = {too_cold, too_hot, mode, fan_on}
    function automatic logic [11:0] exp_vec(input logic [3:0] raw, input logic [7:0] m);
        return {raw[3] ^ m[0], m[0], raw[2] ^ m[1], m[1],
                raw[1] ^ m[2], m[2], raw[0] ^ m[3], m[3],
                m[4], m[5], m[6], m[7]};
    endfunction

    task automatic drive_raw(input logic [3:0] raw);
        {too_cold, too_hot, mode, fan_on} = raw;
    endtask

    // One clock: sample mid-cycle, run the scoreboard, then follow the edge.
    task automatic cycle();
        logic [11:0] exp;
        #1;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        last_accept    = in_valid && in_ready;
        if (!rst_n) begin
            sb_q.delete();
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                failed++;
                $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
            end
        end else begin
            if (out_valid) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    failed++;
                    $display("FAIL spurious_valid: out_valid=1 bundle=%h with nothing expected", dut_vec);
                end else begin
                    exp = out_ready ? sb_q.pop_front() : sb_q[0];
                    if (out_ready) popped++;
                    if (dut_vec !== exp) begin
                        failed++;
                        $display("FAIL bundle: got %h, required %h", dut_vec, exp);
                    end
                end
            end
            if (last_accept) begin
                sb_q.push_back(exp_vec({too_cold, too_hot, mode, fan_on}, mdl_lfsr[7:0]));
                pushed++;
            end
        end
        @(posedge clk);
        mdl_lfsr = rst_n ? step8(mdl_lfsr) : SEED;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; drive_raw(4'b1111);
        repeat (3) cycle();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut_vec !== 12'h000) begin
            failed++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b outs=%h, required 0 0 000",
                     out_valid, in_ready, dut_vec);
        end
    endtask

    task automatic test_warmup_encode();
        int zeros = 0;
        bit found = 0;
        logic [7:0] m_acc = '0;
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b0; drive_raw(4'b1011);
        for (int k = 0; k < 20; k++) begin
            m_acc = mdl_lfsr[7:0];
            cycle();
            if (last_in_ready) begin found = 1; break; end
            zeros++;
        end
        tests_run++;
        if (!found || zeros != 4) begin
            failed++;
            $display("FAIL warmup_len: in_ready low for %0d cycles (rose=%0d), required 4", zeros, found);
        end
        cycle();
        tests_run++;
        if (last_out_valid !== 1'b1) begin
            failed++;
            $display("FAIL out_valid_rise: got %b, required 1", last_out_valid);
        end
        tests_run++;
        if ({too_cold0 ^ too_cold1, too_hot0 ^ too_hot1, mode0 ^ mode1, fan_on0 ^ fan_on1} !== 4'b1011) begin
            failed++;
            $display("FAIL share_xor: got %b, required 1011",
                     {too_cold0 ^ too_cold1, too_hot0 ^ too_hot1, mode0 ^ mode1, fan_on0 ^ fan_on1});
        end
        tests_run++;
        if ({r3, r2, r1, r0} !== m_acc[7:4]) begin
            failed++;
            $display("FAIL r_bits: got r3..r0=%b, required %b", {r3, r2, r1, r0}, m_acc[7:4]);
        end
    endtask

    task automatic test_stall();
        logic [11:0] snap;
        snap = dut_vec;
        drive_raw(4'b0110); in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            tests_run++;
            if (last_in_ready !== 1'b0 || dut_vec !== snap) begin
                failed++;
                $display("FAIL stall_%0d: in_ready=%b outs=%h, required 0 %h", k, last_in_ready, dut_vec, snap);
            end
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        tests_run++;
        if (last_out_valid !== 1'b1 || pushed != popped) begin
            failed++;
            $display("FAIL stall_reload: out_valid=%b pushed=%0d popped=%0d, required 1 and equal",
                     last_out_valid, pushed, popped);
        end
        cycle();
        tests_run++;
        if (last_out_valid !== 1'b0 || last_in_ready !== 1'b1) begin
            failed++;
            $display("FAIL drain_empty: out_valid=%b in_ready=%b, required 0 1", last_out_valid, last_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int cyc     = 0;
        int pop0    = popped;
        in_valid = 1'b1; out_ready = 1'b1;
        while (accepts < 100 && cyc < 200) begin
            drive_raw(4'($urandom_range(0, 15)));
            cycle();
            if (last_accept) accepts++;
            cyc++;
        end
        tests_run++;
        if (accepts != 100 || cyc != 100) begin
            failed++;
            $display("FAIL b2b_rate: %0d accepts in %0d cycles, required 100 in 100", accepts, cyc);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5 && sb_q.size() != 0; k++) cycle();
        tests_run++;
        if (popped - pop0 != 100 || sb_q.size() != 0) begin
            failed++;
            $display("FAIL b2b_count: %0d bundles out, %0d left, required 100 and 0", popped - pop0, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 1'b0; drive_raw(4'b1111);
        cycle();
        cycle();
        tests_run++;
        if (last_out_valid !== 1'b1) begin
            failed++;
            $display("FAIL mid_full: out_valid=%b, required 1", last_out_valid);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        tests_run++;
        if (dut_vec !== 12'h000) begin
            failed++;
            $display("FAIL mid_discard: outs=%h, required 000", dut_vec);
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            tests_run++;
            if (last_out_valid !== 1'b0 || last_in_ready !== 1'b0) begin
                failed++;
                $display("FAIL mid_warmup_%0d: out_valid=%b in_ready=%b, required 0 0",
                         k, last_out_valid, last_in_ready);
            end
        end
    endtask

    initial begin
        mdl_lfsr = SEED;
        test_reset();
        test_warmup_encode();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
